// File: rtl/tbu_pkg.sv
// Shared types and constants for the traceback-unit survivor-memory read arbiter.
package tbu_pkg;

    localparam int S          = 120;
    localparam int NUM_STATES = 64;
    localparam int DATA_W     = 36;
    localparam int OWNER_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
        logic               err;
    } tag_t;

endpackage

// File: rtl/tbu_rd_arbiter_rr_pick.sv
// Round-robin selector: one-hot grant, search starts at the index after the last grant.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt
);
    import tbu_pkg::*;

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PTR_W'((int'(last) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tbu_rd_arbiter.sv
// Shares one survivor-memory read port among NUM_REQ traceback pointers.
// Optional grant/conflict statistics are enabled with macro TBU_ARB_STATS_EN.
module tbu_rd_arbiter #(
    parameter int  NUM_REQ = 2,
    parameter int  S       = 120,
    parameter int  DATA_W  = 36,
    parameter int  RD_LAT  = 2,
    localparam int ADDR_W  = $clog2(S)
) (
    input  logic                      clk,
    input  logic                      sys_rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      mem_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_dout,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err
`ifdef TBU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     gnt_cnt,
    output logic [15:0]               conflict_cnt
`endif
);
    import tbu_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] pick;
    logic [PTR_W-1:0]   win_ptr;
    logic [ADDR_W-1:0]  win_addr;
    logic               win_err;
    logic               any_gnt;
    logic               tags_busy;
    tag_t               tag_p [RD_LAT+1];
    arb_state_e         state, state_nxt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req  (req),
        .last (rr_ptr),
        .gnt  (pick)
    );

    assign gnt     = (sys_rst || flush) ? '0 : pick;
    assign any_gnt = |gnt;

    always_comb begin
        win_ptr  = '0;
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_ptr  = PTR_W'(i);
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign win_err = (32'(win_addr) >= 32'(S));

    // Issue stage: out-of-range reads are granted but never reach the memory.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            rr_ptr   <= PTR_W'(NUM_REQ - 1);
            mem_en   <= 1'b0;
            mem_addr <= '0;
        end else begin
            if (any_gnt) begin
                rr_ptr <= win_ptr;
            end
            mem_en <= any_gnt && !win_err;
            if (any_gnt && !win_err) begin
                mem_addr <= win_addr;
            end
        end
    end

    // Tag pipeline: stage RD_LAT lines up with mem_dout for the read it describes.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_p[k] <= '0;
            end
        end else begin
            tag_p[0] <= '{valid: any_gnt, owner: OWNER_W'(win_ptr), err: any_gnt && win_err};
            for (int k = 1; k <= RD_LAT; k++) begin
                tag_p[k] <= tag_p[k-1];
            end
            if (flush) begin
                for (int k = 0; k <= RD_LAT; k++) begin
                    tag_p[k].valid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        tags_busy = 1'b0;
        for (int k = 0; k <= RD_LAT; k++) begin
            tags_busy = tags_busy | tag_p[k].valid;
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = tag_p[RD_LAT].valid && (tag_p[RD_LAT].owner == OWNER_W'(i));
        end
    end

    assign rsp_err  = tag_p[RD_LAT].valid && tag_p[RD_LAT].err;
    assign rsp_data = (tag_p[RD_LAT].valid && !tag_p[RD_LAT].err) ? mem_dout : '0;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (flush) begin
                    state_nxt = ST_DRAIN;
                end else if (|req) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_nxt = ST_DRAIN;
                end else if (|req) begin
                    state_nxt = ST_BUSY;
                end else if (tags_busy) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    state_nxt = ST_DRAIN;
                end else if (|req) begin
                    state_nxt = ST_BUSY;
                end else if (!tags_busy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef TBU_ARB_STATS_EN
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            gnt_cnt      <= '0;
            conflict_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && (gnt_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    gnt_cnt[i*16 +: 16] <= gnt_cnt[i*16 +: 16] + 16'd1;
                end
            end
            if (($countones(req) >= 2) && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/tbu_rd_arbiter.md
TBU_RD_ARBITER -- requirements
Module: tbu_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, the number of traceback read pointers sharing one survivor-memory read port.
REQ-002 SHALL have parameter S, default 120, the survivor-memory depth in trellis stages; ADDR_W = $clog2(S).
REQ-003 SHALL have parameter DATA_W, default 36, the width of one survivor-memory row word.
REQ-004 SHALL have parameter RD_LAT, default 2, the memory read latency in cycles (2 = HIGH_PERFORMANCE BRAM).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-006 SHALL have port sys_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port flush, input, 1 bit: synchronous drop of all in-flight reads.
REQ-008 SHALL have port req, input, NUM_REQ bits: per-pointer read request, held until granted.
REQ-009 SHALL have port req_addr, input, NUM_REQ x ADDR_W: per-pointer column address.
REQ-010 SHALL have port gnt, output, NUM_REQ bits: combinational, one-hot or zero; request consumed this cycle.
REQ-011 SHALL have port mem_en, output, 1 bit: registered read enable to the memory port.
REQ-012 SHALL have port mem_addr, output, ADDR_W bits: registered read address to the memory port.
REQ-013 SHALL have port mem_dout, input, DATA_W bits: memory read data, valid RD_LAT cycles after mem_en.
REQ-014 SHALL have port rsp_valid, output, NUM_REQ bits: one-hot pulse marking the owner of rsp_data.
REQ-015 SHALL have port rsp_data, output, DATA_W bits: returned row word.
REQ-016 SHALL have port rsp_err, output, 1 bit: the returned read had an out-of-range address.

Function
REQ-017 SHALL grant at most one requester per cycle, chosen round-robin starting from the index after the last granted index.
REQ-018 SHALL assert gnt[i] in the same cycle that req[i] is high and i wins arbitration; a requester not granted keeps req high and its address stable.
REQ-019 SHALL, on a grant, register mem_addr = req_addr[winner] and mem_en = 1 on the next edge; when there is no grant, mem_en = 0 and mem_addr holds its value.
REQ-020 SHALL track each issued read in an RD_LAT+1-deep tag pipeline of {valid, owner index, err}.
REQ-021 SHALL pulse rsp_valid[owner] for exactly one cycle, with rsp_data = mem_dout, RD_LAT+1 cycles after the grant cycle (grant at cycle t gives the response at cycle t+RD_LAT+1).
REQ-022 SHALL sustain one grant per cycle with no bubbles under continuous requests.
REQ-023 SHALL, when req_addr[winner] >= S, grant normally but force mem_en = 0 and return the response at the normal latency with rsp_err = 1 and rsp_data = 0.
REQ-024 SHALL advance the round-robin pointer only on a grant; with a single active requester it SHALL be granted every cycle.
REQ-025 SHALL, on flush, clear every pending tag valid bit and suppress any grant and mem_en in that same cycle (gnt = 0); the round-robin pointer is held.
REQ-026 SHALL implement a state machine with states IDLE (no tag in flight, no request), BUSY (a request present or a tag in flight) and DRAIN (flush asserted or tags retiring with no request); it SHALL move DRAIN to IDLE once the tag pipeline is empty.

Reset
REQ-027 SHALL asynchronously clear on sys_rst: gnt = 0, mem_en = 0, mem_addr = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, all tags invalid, round-robin pointer = NUM_REQ-1 (so index 0 wins first), state = IDLE.
REQ-028 SHALL, when reset is asserted mid-operation, deliver no response for any read issued before reset.

Configuration
REQ-029 SHALL, with macro TBU_ARB_STATS_EN defined, add outputs gnt_cnt (NUM_REQ x 16-bit, saturating grant counts) and conflict_cnt (16-bit, saturating count of cycles with two or more requests); both SHALL clear on sys_rst.
REQ-030 SHALL, without TBU_ARB_STATS_EN, omit those ports and counters entirely, with all other behaviour identical.

Structure
REQ-031 SHALL place the arbiter state enum, the tag struct {valid, owner, err}, and the constants S, NUM_STATES = 64 and DATA_W = 36 in shared package tbu_pkg.
REQ-032 SHALL implement the round-robin selector as sub-module rr_pick (combinational: req, last-grant pointer -> one-hot gnt).

Verification
REQ-033 Single requester: req[0] held for 4 cycles, addresses 5..8 -> gnt[0] in 4 consecutive cycles, rsp_valid[0] at t+3..t+6 carrying words 5..8.
REQ-034 Contention: req = 2'b11 for 4 cycles after reset -> grants in the order 0,1,0,1; conflict_cnt = 4 with TBU_ARB_STATS_EN.
REQ-035 Out of range: req_addr[1] = 120 -> mem_en stays 0 and rsp_valid[1] with rsp_err = 1, rsp_data = 0 at t+3.
REQ-036 Flush: grants at t and t+1, flush at t+2 -> no rsp_valid at t+3 or t+4, and state reaches IDLE.
REQ-037 Reset mid-flight: sys_rst asserted one cycle after a grant -> all outputs 0 immediately, no later response.
REQ-038 Wrap: address 119 then 0 from req[0] -> two responses in order, with matching data.
